jk_counter_ctrl: RTL and testbench

Sequencer for a bank of JK flip-flop cells that forms a programmable up/down modulo-N counter stepping at a slow display rate.
- Derives a one-cycle tick enable from the board clock.
- Runs a small run/pause FSM and computes the J/K inputs for every bit each tick.
- Sits between front-panel controls (buttons/switches) and LED outputs; replaces hand-wired JK chains with one controlled block.

---
 rtl/jk_ctrl_pkg.sv | 14 +
 rtl/jk_cell.sv | 31 +++
 rtl/jk_counter_ctrl.sv | 115 +++++++++++
 tb/tb_jk_counter_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_ctrl_pkg.sv
// Shared constants for the JK counter controller: FSM state codes and the
// two-bit {J,K} codes understood by a single JK cell.
package jk_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop cell: rising-edge, asynchronous active-high Clear,
// complementary Q/Qb outputs.
module jk_cell
    import jk_ctrl_pkg::*;
(
    input  logic clk,
    input  logic Clear,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    // Classic JK behaviour: hold, reset, set or toggle on each clock edge.
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Programmable up/down modulo-N counter built from WIDTH JK cells.
// The controller owns the tick divider, the run/pause FSM and the per-bit
// J/K vectors; the cells hold the count itself.
module jk_counter_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1
) (
    input  logic             clk,
    input  logic             Clear,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tick,
    output logic             tc,
    output logic             busy
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [DW-1:0]    div_cnt;
    logic             step;
    logic             wrap;
    logic [WIDTH-1:0] j_v;
    logic [WIDTH-1:0] k_v;

    assign tick = (state == ST_RUN) && (div_cnt == DIV_LAST);
    assign step = tick && !load;
    assign wrap = up_dn ? (q >= modulus) : (q == '0);

    // Run/pause sequencing; stop dominates start while running or paused.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start)          state_nx = ST_RUN;
            ST_RUN:   if (stop)           state_nx = ST_PAUSE;
            ST_PAUSE: if (start && !stop) state_nx = ST_RUN;
            default:                      state_nx = ST_IDLE;
        endcase
    end

    // FSM, busy flag, tick divider and registered terminal-count strobe.
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            div_cnt <= '0;
            tc      <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == ST_RUN);
            if (state != ST_RUN && state_nx == ST_RUN) begin
                div_cnt <= '0;
            end else if (state == ST_RUN) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end
            tc <= step && wrap;
        end
    end

    // J/K vectors: load forces each bit, a step toggles the carry/borrow
    // chain, a wrap forces zero (up) or the modulus (down); otherwise hold.
    always_comb begin
        logic chain;
        j_v   = '0;
        k_v   = '0;
        chain = 1'b1;
        if (load) begin
            j_v = load_val;
            k_v = ~load_val;
        end else if (step) begin
            if (up_dn && !wrap) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    j_v[i] = chain;
                    k_v[i] = chain;
                    chain  = chain & q[i];
                end
            end else if (up_dn) begin
                k_v = '1;
            end else if (!wrap) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    j_v[i] = chain;
                    k_v[i] = chain;
                    chain  = chain & ~q[i];
                end
            end else begin
                j_v = modulus;
                k_v = ~modulus;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .Clear (Clear),
            .j     (j_v[g]),
            .k     (k_v[g]),
            .q     (q[g]),
            .qb    (qb[g])
        );
    end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Self-checking bench for jk_counter_ctrl with a 4-cycle tick divider.
module tb_jk_counter_ctrl;

    localparam int DIV   = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk = 1'b0;
    logic       Clear = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] modulus = '0;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tick;
    logic       tc;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode, cycles spent in RUN since entry, count value.
    int m_mode = M_IDLE;
    int m_cnt  = 0;
    int m_q    = 0;
    bit m_tc   = 1'b0;

    jk_counter_ctrl #(.WIDTH(4), .CLK_HZ(4), .TICK_HZ(1)) dut (
        .clk      (clk),
        .Clear    (Clear),
        .start    (start),
        .stop     (stop),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .modulus  (modulus),
        .q        (q),
        .qb       (qb),
        .tick     (tick),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_tick(input int md, input int cnt);
        return (md == M_RUN) && ((cnt % DIV) == DIV - 1);
    endfunction

    function automatic int next_q(input int cq, input int m, input bit up,
                                  input bit ld, input int lv, input bit stp);
        if (ld)   return lv;
        if (!stp) return cq;
        if (up)   return (cq >= m) ? 0 : cq + 1;
        return (cq == 0) ? m : cq - 1;
    endfunction

    function automatic bit next_tc(input int cq, input int m, input bit up,
                                   input bit ld, input bit stp);
        if (ld || !stp) return 1'b0;
        return up ? (cq >= m) : (cq == 0);
    endfunction

    function automatic int next_mode(input int md, input bit st, input bit sp);
        if (md == M_RUN) return sp ? M_PAUSE : M_RUN;
        if (st && (md == M_IDLE || !sp)) return M_RUN;
        return md;
    endfunction

    function automatic int next_cnt(input int md, input int cnt, input bit st, input bit sp);
        int nm;
        nm = next_mode(md, st, sp);
        if (md != M_RUN && nm == M_RUN) return 0;
        if (md == M_RUN) return (cnt + 1) % DIV;
        return cnt;
    endfunction

    // Reference model advance.
    always @(posedge clk or posedge Clear) begin
        if (Clear) begin
            m_mode <= M_IDLE;
            m_cnt  <= 0;
            m_q    <= 0;
            m_tc   <= 1'b0;
        end else begin
            m_q    <= next_q(m_q, int'(modulus), up_dn, load, int'(load_val),
                             model_tick(m_mode, m_cnt));
            m_tc   <= next_tc(m_q, int'(modulus), up_dn, load, model_tick(m_mode, m_cnt));
            m_mode <= next_mode(m_mode, start, stop);
            m_cnt  <= next_cnt(m_mode, m_cnt, start, stop);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("q",    int'(q),    m_q);
        check("qb",   int'(qb),   (~m_q) & 15);
        check("tick", int'(tick), int'(model_tick(m_mode, m_cnt)));
        check("tc",   int'(tc),   int'(m_tc));
        check("busy", int'(busy), int'(m_mode == M_RUN));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (tick !== 1'b1 && n < 3 * DIV) begin
            cyc();
            n++;
        end
        if (tick !== 1'b1) check("tick_timeout", 0, 1);
    endtask

    task automatic step_wait(output int n);
        wait_tick(n);
        cyc();
        n++;
    endtask

    initial begin
        int n;
        int e;
        int q_frozen;
        int seen;
        #2;
        check("rst_q", int'(q), 0);
        check("rst_qb", int'(qb), 15);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(tick), 0);
        cyc();
        Clear = 1'b0;
        cyc();

        // Up count modulo 5.
        modulus = 4'd5;
        up_dn   = 1'b1;
        start   = 1'b1;
        cyc();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        for (int k = 1; k <= 6; k++) begin
            step_wait(n);
            check("up_period", n, 4);
            e = k % 6;
            check("up_q", int'(q), e);
            check("up_tc", int'(tc), (e == 0) ? 1 : 0);
        end

        // Down count modulo 9 from zero.
        modulus = 4'd9;
        up_dn   = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            step_wait(n);
            e = (k == 0 || k == 10) ? 9 : 9 - k;
            check("dn_q", int'(q), e);
            check("dn_tc", int'(tc), (e == 9) ? 1 : 0);
        end

        // Load coincident with a tick wins; next step wraps with M=5.
        modulus = 4'd5;
        up_dn   = 1'b1;
        wait_tick(n);
        load     = 1'b1;
        load_val = 4'hC;
        cyc();
        load = 1'b0;
        check("load_q", int'(q), 12);
        check("load_tc", int'(tc), 0);
        step_wait(n);
        check("after_load_period", n, 4);
        check("after_load_q", int'(q), 0);
        check("after_load_tc", int'(tc), 1);

        // Pause: frozen, no ticks; start+stop stays paused; restart timing.
        step_wait(n);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("pause_busy", int'(busy), 0);
        q_frozen = int'(q);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (tick === 1'b1) seen++;
            check("pause_q", int'(q), q_frozen);
        end
        check("pause_ticks", seen, 0);
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        check("pause_both_busy", int'(busy), 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("resume_busy", int'(busy), 1);
        step_wait(n);
        check("resume_period", n, 4);
        check("resume_q", int'(q), (q_frozen + 1) % 6);

        // Modulus zero: stays at 0 with tc on every tick.
        modulus = 4'd0;
        for (int k = 0; k < 4; k++) begin
            step_wait(n);
            check("m0_q", int'(q), 0);
            check("m0_tc", int'(tc), 1);
        end

        // Asynchronous Clear mid-run.
        modulus = 4'd9;
        step_wait(n);
        Clear = 1'b1;
        #1;
        check("clr_q", int'(q), 0);
        check("clr_qb", int'(qb), 15);
        check("clr_busy", int'(busy), 0);
        check("clr_tick", int'(tick), 0);
        cyc();
        Clear = 1'b0;
        cyc();
        check("clr_idle_busy", int'(busy), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            start    = ($urandom % 8) == 0;
            stop     = ($urandom % 10) == 0;
            load     = ($urandom % 12) == 0;
            load_val = 4'($urandom);
            if (($urandom % 20) == 0) up_dn = ~up_dn;
            if (($urandom % 40) == 0) modulus = 4'($urandom);
            Clear    = ($urandom % 300) == 0;
            cyc();
        end
        Clear = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
